// File: rtl/dot_product_row_feeder.sv
// Row sequencer for the eight-unit dot-product stage: reads each row's package
// count, pulses the unit's per-row reset, then streams matrix/vector packages.
module dot_product_row_feeder #(
   parameter int no_of_units                  = 8,
   parameter int element_width                = 32,
   parameter int multiples_memory_value_width = 3,
   parameter int row_addr_width               = 8,
   parameter int mem_addr_width               = 10
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic [row_addr_width-1:0]                no_of_rows,
   input  logic [mem_addr_width-1:0]                mat_base_addr,
   output logic [row_addr_width-1:0]                row_len_addr,
   input  logic [multiples_memory_value_width-1:0]  row_len_data,
   output logic [mem_addr_width-1:0]                mat_rd_addr,
   input  logic [element_width*no_of_units-1:0]     mat_rd_data,
   output logic [mem_addr_width-1:0]                vec_rd_addr,
   input  logic [element_width*no_of_units-1:0]     vec_rd_data,
   output logic                                     dp_reset,
   output logic [multiples_memory_value_width-1:0]  dp_no_of_multiples,
   output logic                                     dp_read_now,
   output logic [element_width*no_of_units-1:0]     first_row,
   output logic [element_width*no_of_units-1:0]     second_row,
   input  logic                                     dp_prepare_new_input,
   output logic                                     busy,
   output logic                                     done
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_RD,
      LEN_CHK,
      ROW_START,
      FETCH,
      ISSUE,
      WAIT_PREP
   } state_t;

   state_t                                    state;
   logic [row_addr_width-1:0]                 row_idx;
   logic [row_addr_width-1:0]                 rows_q;
   logic [multiples_memory_value_width-1:0]   pkg_idx;
   logic [mem_addr_width-1:0]                 mat_ptr;

   logic                                      last_row;
   logic                                      last_pkg;
   logic [row_addr_width-1:0]                 next_row;
   logic [multiples_memory_value_width-1:0]   next_pkg;

   assign last_row = (row_idx == rows_q - row_addr_width'(1));
   // dp_no_of_multiples doubles as the captured row length for the current row
   assign last_pkg = (pkg_idx == dp_no_of_multiples - multiples_memory_value_width'(1));
   assign next_row = row_idx + row_addr_width'(1);
   assign next_pkg = pkg_idx + multiples_memory_value_width'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         row_idx            <= '0;
         rows_q             <= '0;
         pkg_idx            <= '0;
         mat_ptr            <= '0;
         row_len_addr       <= '0;
         mat_rd_addr        <= '0;
         vec_rd_addr        <= '0;
         dp_reset           <= 1'b0;
         dp_no_of_multiples <= '0;
         dp_read_now        <= 1'b0;
         first_row          <= '0;
         second_row         <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         done        <= 1'b0;
         dp_reset    <= 1'b0;
         dp_read_now <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  rows_q  <= no_of_rows;
                  row_idx <= '0;
                  mat_ptr <= mat_base_addr;
                  if (no_of_rows == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy         <= 1'b1;
                     row_len_addr <= '0;
                     state        <= LEN_RD;
                  end
               end
            end

            LEN_RD: state <= LEN_CHK;

            LEN_CHK: begin
               if (row_len_data == '0) begin
                  // empty row: advance without touching the dot-product unit
                  if (last_row) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     row_idx      <= next_row;
                     row_len_addr <= next_row;
                     state        <= LEN_RD;
                  end
               end else begin
                  dp_reset           <= 1'b1;
                  dp_no_of_multiples <= row_len_data;
                  pkg_idx            <= '0;
                  state              <= ROW_START;
               end
            end

            ROW_START: begin
               mat_rd_addr <= mat_ptr;
               vec_rd_addr <= mem_addr_width'(pkg_idx);
               mat_ptr     <= mat_ptr + mem_addr_width'(1);
               state       <= FETCH;
            end

            FETCH: state <= ISSUE;

            ISSUE: begin
               first_row   <= mat_rd_data;
               second_row  <= vec_rd_data;
               dp_read_now <= 1'b1;
               if (last_pkg) begin
                  state <= WAIT_PREP;
               end else begin
                  // next slot's addresses go out alongside this package's strobe
                  pkg_idx     <= next_pkg;
                  mat_rd_addr <= mat_ptr;
                  vec_rd_addr <= mem_addr_width'(next_pkg);
                  mat_ptr     <= mat_ptr + mem_addr_width'(1);
                  state       <= FETCH;
               end
            end

            WAIT_PREP: begin
               if (dp_prepare_new_input) begin
                  if (last_row) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     row_idx      <= next_row;
                     row_len_addr <= next_row;
                     state        <= LEN_RD;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
